// File: rtl/iob_ila_dump.sv
// iob_ila_dump: readout engine that drains ILA samples over IOb-Native and
// pushes every sample word onto a valid/ready stream.
//
// Ports
//   clk_i, cke_i, rst_i : clock, clock enable (low = hold all state),
//                         synchronous active-high reset
//   start_i             : one-cycle pulse, starts a dump when idle
//   busy_o, done_o      : dump in progress / one-cycle end-of-dump pulse
//   count_o             : samples fully streamed in the current/last dump
//   iob_*               : IOb-Native master towards the ILA CSR port
//   m_data_o, m_valid_o, m_last_o, m_ready_i : output word stream
//
// Handshakes: a bus request (avalid/addr/wdata/wstrb) is held unchanged until
// the cycle iob_ready_i=1; avalid drops on the following cycle. A read then
// completes on the first iob_rvalid_i at or after that ready cycle. A stream
// word (m_data_o/m_last_o) is held with m_valid_o=1 until the cycle
// m_ready_i=1.
module iob_ila_dump #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter int                SIGNAL_W   = 64,
  parameter int                BUFFER_W   = 10,
  parameter logic [ADDR_W-1:0] ADDR_INDEX = 5'h10,
  parameter logic [ADDR_W-1:0] ADDR_SEL   = 5'h12,
  parameter logic [ADDR_W-1:0] ADDR_DATA  = 5'h14,
  parameter logic [ADDR_W-1:0] ADDR_NSAMP = 5'h18
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BUFFER_W-1:0]   count_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  output logic [DATA_W-1:0]     m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  localparam int N_WORDS = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int W_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int STRB_W  = DATA_W / 8;
  localparam int IDX_SH  = 8 * int'(ADDR_INDEX[1:0]);
  localparam int SEL_SH  = 8 * int'(ADDR_SEL[1:0]);
  localparam logic [W_W-1:0]    W_LAST   = W_W'(N_WORDS - 1);
  localparam logic [STRB_W-1:0] IDX_STRB = STRB_W'(2'b11) << ADDR_INDEX[1:0];
  localparam logic [STRB_W-1:0] SEL_STRB = STRB_W'(1'b1) << ADDR_SEL[1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_RD_NS, S_WR_IDX, S_WR_SEL, S_RD_DAT, S_PUSH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                issued_q, issued_d;   // request of the current state launched
  logic                rwait_q, rwait_d;     // read accepted, waiting for rvalid
  logic [BUFFER_W-1:0] n_q, n_d;
  logic [BUFFER_W-1:0] idx_q, idx_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [BUFFER_W-1:0] count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                avalid_q, avalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;

  logic                is_bus;
  logic                bus_done;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [STRB_W-1:0]   req_wstrb;
  logic [BUFFER_W-1:0] n_last;

  assign n_last = n_q - BUFFER_W'(1);

  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    rwait_d   = rwait_q;
    n_d       = n_q;
    idx_d     = idx_q;
    w_d       = w_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    avalid_d  = avalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    is_bus    = 1'b1;
    bus_done  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    // Request owned by each bus state; a zero strobe marks a read.
    case (state_q)
      S_RD_NS:  req_addr = ADDR_NSAMP;
      S_WR_IDX: begin
        req_addr  = ADDR_INDEX;
        req_wdata = DATA_W'(idx_q) << IDX_SH;
        req_wstrb = IDX_STRB;
      end
      S_WR_SEL: begin
        req_addr  = ADDR_SEL;
        req_wdata = DATA_W'(w_q) << SEL_SH;
        req_wstrb = SEL_STRB;
      end
      S_RD_DAT: req_addr = ADDR_DATA;
      default:  is_bus = 1'b0;
    endcase

    // Single-outstanding transaction sequencer shared by all bus states.
    // The first cycle in a state launches the request, so avalid is always
    // low for at least one cycle between two transactions.
    if (is_bus) begin
      if (!issued_q) begin
        issued_d = 1'b1;
        avalid_d = 1'b1;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        wstrb_d  = req_wstrb;
      end else if (avalid_q) begin
        if (iob_ready_i) begin
          avalid_d = 1'b0;
          if ((wstrb_q != '0) || iob_rvalid_i) bus_done = 1'b1;
          else rwait_d = 1'b1;
        end
      end else if (rwait_q && iob_rvalid_i) begin
        bus_done = 1'b1;
      end
      if (bus_done) begin
        issued_d = 1'b0;
        rwait_d  = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RD_NS;
          busy_d  = 1'b1;
          count_d = '0;
        end
      end
      S_RD_NS: begin
        if (bus_done) begin
          n_d = iob_rdata_i[BUFFER_W-1:0];
          if (iob_rdata_i[BUFFER_W-1:0] == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = S_WR_IDX;
          end
        end
      end
      S_WR_IDX: begin
        if (bus_done) begin
          w_d     = '0;
          state_d = S_WR_SEL;
        end
      end
      S_WR_SEL: begin
        if (bus_done) state_d = S_RD_DAT;
      end
      S_RD_DAT: begin
        if (bus_done) begin
          m_data_d  = iob_rdata_i;
          m_valid_d = 1'b1;
          m_last_d  = (w_q == W_LAST) && (idx_q == n_last);
          state_d   = S_PUSH;
        end
      end
      S_PUSH: begin
        if (m_ready_i) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (w_q != W_LAST) begin
            w_d     = w_q + W_W'(1);
            state_d = S_WR_SEL;
          end else begin
            count_d = count_q + BUFFER_W'(1);
            if (idx_q == n_last) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + BUFFER_W'(1);
              state_d = S_WR_IDX;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      issued_q  <= 1'b0;
      rwait_q   <= 1'b0;
      n_q       <= '0;
      idx_q     <= '0;
      w_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      avalid_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      rwait_q   <= rwait_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      w_q       <= w_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      avalid_q  <= avalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign count_o      = count_q;
  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;
  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;

endmodule

// File: tb/tb_iob_ila_dump.sv
// Testbench for iob_ila_dump: an ILA CSR model answers the bus, a sink
// collects the stream, and each dump is compared against words and bus
// operations derived from the sample memory contents.
module tb_iob_ila_dump;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int SIGNAL_W = 64;
  localparam int BUFFER_W = 10;
  localparam int N_WORDS  = 2;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic cke_i = 1'b1;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_seen = 1'b1;
  always @(posedge clk_i) rst_seen <= rst_i;

  logic                busy_o, done_o;
  logic [BUFFER_W-1:0] count_o;
  logic                iob_avalid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i = 1'b0;
  logic                iob_rvalid_i = 1'b0;
  logic [DATA_W-1:0]   iob_rdata_i = '0;
  logic [DATA_W-1:0]   m_data_o;
  logic                m_valid_o, m_last_o;
  logic                m_ready_i = 1'b0;

  iob_ila_dump #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W)
  ) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
    .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ILA CSR model ----------------
  logic [7:0]  regs [0:31];
  logic [31:0] nsamp_reg = '0;
  logic [63:0] sig_mem [0:1023];
  logic [40:0] bus_log [$];          // {addr, wstrb, wdata}; reads log wdata=0
  int          rdy_dly = 0;
  int          rv_dly = 1;
  int          wait_cnt = 0;
  int          rv_cnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rd_val;
  logic        p_av = 1'b0;
  logic [40:0] p_req = '0;

  function automatic logic [31:0] sample_word(input logic [15:0] index, input logic [7:0] sel);
    logic [63:0] s;
    s = sig_mem[index[9:0]];
    if (sel == 8'd0) return s[31:0];
    else if (sel == 8'd1) return s[63:32];
    else return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk_i) begin
    // a request not accepted on the last edge must be presented unchanged
    if (!rst_seen && p_av && !iob_ready_i) begin
      chk("req_hold_avalid", 64'(iob_avalid_o), 64'd1);
      chk("req_hold_fields", 64'({iob_addr_o, iob_wstrb_o, iob_wdata_o}), 64'(p_req));
    end
    p_av  = iob_avalid_o;
    p_req = {iob_addr_o, iob_wstrb_o, iob_wdata_o};

    iob_ready_i  = 1'b0;
    iob_rvalid_i = 1'b0;
    iob_rdata_i  = $urandom;
    if (rv_pend) begin
      if (rv_cnt <= 1) begin
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = rd_val;
        rv_pend      = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (iob_avalid_o) begin
      if (wait_cnt < rdy_dly) begin
        wait_cnt++;
      end else begin
        wait_cnt    = 0;
        iob_ready_i = 1'b1;
        if (iob_wstrb_o != '0) begin
          for (int b = 0; b < 4; b++)
            if (iob_wstrb_o[b]) regs[int'({iob_addr_o[4:2], 2'b00}) + b] = iob_wdata_o[8*b +: 8];
          bus_log.push_back({iob_addr_o, iob_wstrb_o, iob_wdata_o});
        end else begin
          bus_log.push_back({iob_addr_o, 4'b0000, 32'h0});
          if (iob_addr_o == 5'h18) rd_val = nsamp_reg;
          else if (iob_addr_o == 5'h14) rd_val = sample_word({regs[17], regs[16]}, regs[18]);
          else rd_val = 32'hDEAD_BEEF;
          if (rv_dly == 0) begin
            iob_rvalid_i = 1'b1;
            iob_rdata_i  = rd_val;
          end else begin
            rv_pend = 1'b1;
            rv_cnt  = rv_dly;
          end
        end
      end
    end
  end

  // ---------------- stream sink ----------------
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];             // scoreboard: {last, data}
  int          sink_mode = 0;         // 0 always ready, 1 random, 2 one 5-cycle stall on word 2
  int          stall_left = 0;
  bit          stall_used = 1'b0;
  logic        p_mv = 1'b0;
  logic [32:0] p_mdat = '0;

  always @(negedge clk_i) begin
    if (!rst_seen && p_mv && !m_ready_i) begin
      chk("stream_hold_valid", 64'(m_valid_o), 64'd1);
      chk("stream_hold_data", 64'({m_last_o, m_data_o}), 64'(p_mdat));
    end
    if (!rst_seen && m_valid_o) chk("no_bus_in_push", 64'(iob_avalid_o), 64'd0);
    p_mv   = m_valid_o;
    p_mdat = {m_last_o, m_data_o};

    if (stall_left > 0) begin
      m_ready_i = 1'b0;
      stall_left--;
    end else if (sink_mode == 2 && !stall_used && m_valid_o && got_q.size() == 2) begin
      stall_used = 1'b1;
      stall_left = 4;
      m_ready_i  = 1'b0;
    end else if (sink_mode == 1) begin
      m_ready_i = 1'($urandom_range(0, 1));
    end else begin
      m_ready_i = 1'b1;
    end
    if (m_valid_o && m_ready_i) got_q.push_back({m_last_o, m_data_o});
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},   64'(busy_o), 64'd0);
    chk({tag, "_done"},   64'(done_o), 64'd0);
    chk({tag, "_count"},  64'(count_o), 64'd0);
    chk({tag, "_avalid"}, 64'(iob_avalid_o), 64'd0);
    chk({tag, "_addr"},   64'(iob_addr_o), 64'd0);
    chk({tag, "_wdata"},  64'(iob_wdata_o), 64'd0);
    chk({tag, "_wstrb"},  64'(iob_wstrb_o), 64'd0);
    chk({tag, "_mdata"},  64'(m_data_o), 64'd0);
    chk({tag, "_mvalid"}, 64'(m_valid_o), 64'd0);
    chk({tag, "_mlast"},  64'(m_last_o), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_dump(input logic [31:0] nsamp, input int rdy, input int rv, input int mode,
                          input logic [9:0] exp_cnt, input int exp_lat, input bit dbl,
                          input string tag);
    int n;
    int cyc;
    logic [40:0] eb [$];
    n = int'(nsamp[BUFFER_W-1:0]);
    nsamp_reg  = nsamp;
    rdy_dly    = rdy;
    rv_dly     = rv;
    sink_mode  = mode;
    stall_used = 1'b0;
    for (int s = 0; s < n; s++) sig_mem[s] = {$urandom, $urandom};
    // expected words: samples in order, least significant word first
    exp_q.delete();
    got_q.delete();
    bus_log.delete();
    eb.push_back({5'h18, 4'b0000, 32'h0});
    for (int s = 0; s < n; s++) begin
      eb.push_back({5'h10, 4'b0011, 32'(s)});
      for (int w = 0; w < N_WORDS; w++) begin
        eb.push_back({5'h12, 4'b0100, 32'(w) << 16});
        eb.push_back({5'h14, 4'b0000, 32'h0});
        exp_q.push_back({(s == n - 1) && (w == N_WORDS - 1), sig_mem[s][32*w +: 32]});
      end
    end

    pulse_start();
    chk({tag, "_busy_after_start"}, 64'(busy_o), 64'd1);
    chk({tag, "_count_cleared"}, 64'(count_o), 64'd0);
    cyc = 0;
    while (!done_o && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
      start_i = dbl && (cyc == 4 || cyc == 12);
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_o), 64'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
    chk({tag, "_count"}, 64'(count_o), 64'(exp_cnt));
    @(negedge clk_i);
    chk({tag, "_done_one_cycle"}, 64'(done_o), 64'd0);

    chk({tag, "_n_words"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_n_bus_ops"}, 64'(bus_log.size()), 64'(eb.size()));
    for (int i = 0; i < eb.size(); i++)
      if (i < bus_log.size()) chk($sformatf("%s_busop%0d", tag, i), 64'(bus_log[i]), 64'(eb[i]));

    repeat (4) @(negedge clk_i);
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_idle_count"}, 64'(count_o), 64'(exp_cnt));
    chk({tag, "_no_extra_bus"}, 64'(bus_log.size()), 64'(eb.size()));
  endtask

  task automatic reset_mid_read();
    int cyc;
    bit seen;
    nsamp_reg = 32'd2;
    rdy_dly   = 0;
    rv_dly    = 4;
    sink_mode = 0;
    for (int s = 0; s < 2; s++) sig_mem[s] = {$urandom, $urandom};
    bus_log.delete();
    got_q.delete();
    pulse_start();
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 500) begin
      @(negedge clk_i);
      cyc++;
      foreach (bus_log[i]) if (bus_log[i][40:36] == 5'h14) seen = 1'b1;
    end
    chk("rst_reached_sample_read", 64'(seen), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle_outputs("mid_reset");
    repeat (8) @(negedge clk_i);
    chk("late_rvalid_busy", 64'(busy_o), 64'd0);
    chk("late_rvalid_mvalid", 64'(m_valid_o), 64'd0);
    chk("late_rvalid_avalid", 64'(iob_avalid_o), 64'd0);
    chk("late_rvalid_words", 64'(got_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [31:0] nsamp;
    int          rdy;
    int          rv;
    int          mode;
    logic [9:0]  cnt;
    int          lat;
    bit          dbl;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    tbl[0] = '{32'd0,          0, 1, 0, 10'd0, 3,  1'b0};  // empty dump
    tbl[1] = '{32'd3,          0, 1, 0, 10'd3, -1, 1'b0};  // basic three samples
    tbl[2] = '{32'd3,          0, 1, 2, 10'd3, -1, 1'b0};  // stall on word 2
    tbl[3] = '{32'd2,          3, 0, 0, 10'd2, -1, 1'b0};  // slow ready, rvalid with ready
    tbl[4] = '{32'h0000_0402,  1, 2, 1, 10'd2, -1, 1'b0};  // upper N_SAMPLES bits ignored
    tbl[5] = '{32'd3,          0, 0, 1, 10'd3, -1, 1'b1};  // start pulses while busy
    tbl[6] = '{32'd1,          2, 2, 0, 10'd1, -1, 1'b0};  // single sample

    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 7; i++)
      run_dump(tbl[i].nsamp, tbl[i].rdy, tbl[i].rv, tbl[i].mode, tbl[i].cnt, tbl[i].lat,
               tbl[i].dbl, $sformatf("row%0d", i));

    reset_mid_read();
    run_dump(32'd2, 0, 1, 0, 10'd2, -1, 1'b0, "after_reset");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      run_dump(32'(n), $urandom_range(0, 2), $urandom_range(0, 2), 1, 10'(n), -1, 1'b0,
               $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
